// File: rtl/pipe_pkg.sv
// Shared pipeline package for the MIPS32 decode/issue path.
//   - control bundle bit positions ({GPRWr, BSel, DMWr, MTR, ALUOp[3:0]})
//   - in-flight writer slot record type and slot indices
//   - forwarding select encodings and the all-zero bubble bundle
package pipe_pkg;

  localparam int GPRWR     = 7;
  localparam int BSEL      = 6;
  localparam int DMWR      = 5;
  localparam int MTR       = 4;
  localparam int ALUOP_MSB = 3;
  localparam int ALUOP_LSB = 0;

  localparam int SIG_W  = 8;
  localparam int REG_W  = 5;
  localparam int NSLOTS = 3;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [SIG_W-1:0] BUBBLE = 8'h00;

  // One in-flight writer: valid, destination, writes GPR, is a load.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } slot_t;

  // Slot entry for an instruction leaving ID.
  function automatic slot_t mk_slot(input logic [REG_W-1:0] rd,
                                    input logic [SIG_W-1:0] sig);
    slot_t s;
    s.v  = 1'b1;
    s.rd = rd;
    s.wr = sig[GPRWR];
    s.ld = sig[MTR];
    return s;
  endfunction

endpackage

// File: rtl/id_issue_if.sv
// ID-stage issue bus between the decoder (master) and id_issue (slave).
//   i_valid/i_rs/i_rt/i_use_rs/i_use_rt/i_rd/i_signals/i_flush : decoder -> issue
//   o_stall/o_signals/o_rd                                    : issue -> pipeline
//   o_fwdA/o_fwdB                                             : only with FORWARD_EN
// Build macro: FORWARD_EN
interface id_issue_if;
  import pipe_pkg::*;

  logic             i_valid;
  logic [REG_W-1:0] i_rs;
  logic [REG_W-1:0] i_rt;
  logic             i_use_rs;
  logic             i_use_rt;
  logic [REG_W-1:0] i_rd;
  logic [SIG_W-1:0] i_signals;
  logic             i_flush;
  logic             o_stall;
  logic [SIG_W-1:0] o_signals;
  logic [REG_W-1:0] o_rd;
`ifdef FORWARD_EN
  logic [1:0]       o_fwdA;
  logic [1:0]       o_fwdB;
`endif

  modport master (
    output i_valid, i_rs, i_rt, i_use_rs, i_use_rt, i_rd, i_signals, i_flush,
`ifdef FORWARD_EN
    input  o_fwdA, o_fwdB,
`endif
    input  o_stall, o_signals, o_rd
  );

  modport slave (
    input  i_valid, i_rs, i_rt, i_use_rs, i_use_rt, i_rd, i_signals, i_flush,
`ifdef FORWARD_EN
    output o_fwdA, o_fwdB,
`endif
    output o_stall, o_signals, o_rd
  );

endinterface

// File: rtl/id_issue_hz_match.sv
// hz_match: does one in-flight writer slot produce the given source register?
//   src/use_src : source index and whether the instruction reads it
//   slot        : writer record
//   match       : RAW dependence on this slot ($0 never matches)
module hz_match
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  slot_t            slot,
  output logic             match
);

  assign match = use_src && slot.v && slot.wr &&
                 (slot.rd == src) && (slot.rd != '0);

endmodule

// File: rtl/id_issue.sv
// id_issue: decode-side issue controller feeding the ID/EX register.
//   clk, rst_n : clock, async active-low reset
//   io (slave) : ID instruction in, stall / bundle / rd (and forward selects) out
// Tracks EX/MEM/WB writers, stalls PC+IF/ID on RAW hazards and injects an
// all-zero bundle into ID/EX. Build macro FORWARD_EN adds registered operand
// forward selects and relaxes the stall rule to load-use only.
module id_issue
  import pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  id_issue_if.slave io
);

  slot_t ex_q, mem_q, wb_q, ex_d;
  slot_t [NSLOTS-1:0] slots;
  logic  [NSLOTS-1:0] mA, mB;
  logic  hazard, stall, bubble;

  assign slots[SLOT_EX]  = ex_q;
  assign slots[SLOT_MEM] = mem_q;
  assign slots[SLOT_WB]  = wb_q;

  // Two comparators per slot: one for rs, one for rt.
  genvar g;
  generate
    for (g = 0; g < NSLOTS; g++) begin : g_slot
      hz_match u_ma (
        .src(io.i_rs), .use_src(io.i_use_rs), .slot(slots[g]), .match(mA[g])
      );
      hz_match u_mb (
        .src(io.i_rt), .use_src(io.i_use_rt), .slot(slots[g]), .match(mB[g])
      );
    end
  endgenerate

`ifdef FORWARD_EN
  // ALU results forward from EX/MEM or MEM/WB; only a load still in EX
  // has no value yet.
  assign hazard = (mA[SLOT_EX] | mB[SLOT_EX]) & ex_q.ld;
`else
  // Register file is write-before-read, so a WB writer is already visible.
  assign hazard = mA[SLOT_EX] | mB[SLOT_EX] | mA[SLOT_MEM] | mB[SLOT_MEM];
`endif

  // A wrong-path instruction is squashed, never stalled.
  assign stall  = io.i_valid & hazard & ~io.i_flush;
  assign bubble = ~io.i_valid | stall | io.i_flush;

  assign io.o_stall   = stall;
  assign io.o_signals = bubble ? BUBBLE : io.i_signals;
  assign io.o_rd      = bubble ? '0     : io.i_rd;

  assign ex_d = bubble ? slot_t'('0) : mk_slot(io.i_rd, io.i_signals);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef FORWARD_EN
  logic [1:0] fwdA_d, fwdA_q, fwdB_d, fwdB_q;

  // Nearest producer wins; captured with ID/EX so it aligns with the EX op.
  always_comb begin
    fwdA_d = FWD_RF;
    fwdB_d = FWD_RF;
    if (!bubble) begin
      if      (mA[SLOT_EX])  fwdA_d = FWD_EXMEM;
      else if (mA[SLOT_MEM]) fwdA_d = FWD_MEMWB;
      if      (mB[SLOT_EX])  fwdB_d = FWD_EXMEM;
      else if (mB[SLOT_MEM]) fwdB_d = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwdA_q <= FWD_RF;
      fwdB_q <= FWD_RF;
    end else begin
      fwdA_q <= fwdA_d;
      fwdB_q <= fwdB_d;
    end
  end

  assign io.o_fwdA = fwdA_q;
  assign io.o_fwdB = fwdB_q;

  // WB matches and load flags beyond EX never affect issue.
  logic unused_ok;
  assign unused_ok = ^{mA[SLOT_WB], mB[SLOT_WB], mem_q.ld, wb_q.ld};
`else
  logic unused_ok;
  assign unused_ok = ^{mA[SLOT_WB], mB[SLOT_WB], ex_q.ld, mem_q.ld, wb_q.ld};
`endif

endmodule
